// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute control sequencer with mfc wait-state timeout
module control_sequencer #(
  parameter int MFC_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        cond_true,
  input  logic        mfc,
  output logic [1:0]  ma,
  output logic [1:0]  mb,
  output logic [1:0]  mf,
  output logic [1:0]  mi,
  output logic [1:0]  mj,
  output logic [2:0]  mc,
  output logic        md,
  output logic        me,
  output logic        mg,
  output logic        mh,
  output logic [4:0]  op,
  output logic        rf_ld,
  output logic        ir_ld,
  output logic        mar_ld,
  output logic        mdr_ld,
  output logic        flags_ld,
  output logic        mem_en,
  output logic        mem_rw,
  output logic        fault,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_F0      = 4'd1,
    S_F1      = 4'd2,
    S_F2      = 4'd3,
    S_DECODE  = 4'd4,
    S_DP      = 4'd5,
    S_LS_ADDR = 4'd6,
    S_LD_WAIT = 4'd7,
    S_LD_WB   = 4'd8,
    S_ST_WAIT = 4'd9,
    S_BR_LINK = 4'd10,
    S_BR      = 4'd11,
    S_FAULT   = 4'd15
  } state_t;

  localparam logic [4:0] OP_PASS_A = 5'h10;
  localparam logic [4:0] OP_ADD    = 5'h04;
  localparam logic [4:0] OP_SUB    = 5'h02;
  localparam logic [7:0] TMO       = 8'(MFC_TIMEOUT);

  state_t     cur;
  state_t     nxt;
  logic [7:0] wait_cnt;
  logic       cur_is_wait;
  logic       nxt_is_wait;
  logic       timed_out;
  logic       unused_ir;

  assign unused_ir   = ^{ir[31:28], ir[22:21], ir[19:0]};
  assign cur_is_wait = (cur == S_F2) || (cur == S_LD_WAIT) || (cur == S_ST_WAIT);
  assign nxt_is_wait = (nxt == S_F2) || (nxt == S_LD_WAIT) || (nxt == S_ST_WAIT);
  assign timed_out   = (wait_cnt == TMO);
  assign state       = cur;

  always_comb begin
    nxt = S_FAULT;
    case (cur)
      S_IDLE:    nxt = S_F0;
      S_F0:      nxt = S_F1;
      S_F1:      nxt = S_F2;
      S_F2: begin
        if (mfc)            nxt = S_DECODE;
        else if (timed_out) nxt = S_FAULT;
        else                nxt = S_F2;
      end
      S_DECODE: begin
        if (!cond_true)               nxt = S_F0;
        else if (ir[27:26] == 2'b00)  nxt = S_DP;
        else if (ir[27:26] == 2'b01)  nxt = S_LS_ADDR;
        else if (ir[27:25] == 3'b101) nxt = ir[24] ? S_BR_LINK : S_BR;
        else                          nxt = S_FAULT;
      end
      S_DP:      nxt = S_F0;
      S_LS_ADDR: nxt = ir[20] ? S_LD_WAIT : S_ST_WAIT;
      S_LD_WAIT: begin
        if (mfc)            nxt = S_LD_WB;
        else if (timed_out) nxt = S_FAULT;
        else                nxt = S_LD_WAIT;
      end
      S_LD_WB:   nxt = S_F0;
      S_ST_WAIT: begin
        if (mfc)            nxt = S_F0;
        else if (timed_out) nxt = S_FAULT;
        else                nxt = S_ST_WAIT;
      end
      S_BR_LINK: nxt = S_BR;
      S_BR:      nxt = S_F0;
      S_FAULT:   nxt = S_FAULT;
      default:   nxt = S_FAULT;
    endcase
  end

  // The counter restarts whenever a wait state is newly entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur      <= S_IDLE;
      wait_cnt <= 8'd0;
    end else begin
      cur <= nxt;
      if (nxt_is_wait && (nxt != cur))
        wait_cnt <= 8'd0;
      else if (cur_is_wait && !mfc)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    ma       = 2'd0;
    mb       = 2'd0;
    mf       = 2'd0;
    mi       = 2'd0;
    mj       = 2'd0;
    mc       = 3'd0;
    md       = 1'b0;
    me       = 1'b0;
    mg       = 1'b0;
    mh       = 1'b0;
    op       = 5'd0;
    rf_ld    = 1'b0;
    ir_ld    = 1'b0;
    mar_ld   = 1'b0;
    mdr_ld   = 1'b0;
    flags_ld = 1'b0;
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    fault    = 1'b0;
    case (cur)
      S_F0: begin
        ma     = 2'd2;
        md     = 1'b1;
        op     = OP_PASS_A;
        mar_ld = 1'b1;
      end
      S_F1: begin
        ma     = 2'd2;
        mb     = 2'd3;
        md     = 1'b1;
        op     = OP_ADD;
        mc     = 3'd3;
        rf_ld  = 1'b1;
        mem_en = 1'b1;
        mem_rw = 1'b1;
      end
      S_F2: begin
        mem_en = 1'b1;
        mem_rw = 1'b1;
        mh     = 1'b1;
        ir_ld  = mfc;
      end
      S_DP: begin
        mb       = 2'd1;
        // Compare-class opcodes (8..11) only update flags.
        rf_ld    = (ir[24:23] != 2'b10);
        flags_ld = ir[20];
      end
      S_LS_ADDR: begin
        mb     = 2'd2;
        md     = 1'b1;
        op     = ir[23] ? OP_ADD : OP_SUB;
        mar_ld = 1'b1;
        if (!ir[20]) begin
          mdr_ld = 1'b1;
          mj     = 2'd2;
          mg     = 1'b1;
        end
      end
      S_LD_WAIT: begin
        mem_en = 1'b1;
        mem_rw = 1'b1;
        mh     = 1'b1;
        mdr_ld = mfc;
      end
      S_LD_WB: begin
        mf    = 2'd1;
        rf_ld = 1'b1;
      end
      S_ST_WAIT: begin
        mem_en = 1'b1;
      end
      S_BR_LINK: begin
        ma    = 2'd2;
        md    = 1'b1;
        op    = OP_PASS_A;
        mc    = 3'd2;
        rf_ld = 1'b1;
      end
      S_BR: begin
        ma    = 2'd2;
        mb    = 2'd2;
        md    = 1'b1;
        op    = OP_ADD;
        mc    = 3'd3;
        rf_ld = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized instruction-level checking of control_sequencer
module tb_control_sequencer;

  localparam int TMO   = 15;
  localparam int LIMIT = TMO + 1;

  logic        clk = 1'b0;
  logic        reset, cond_true, mfc;
  logic [31:0] ir;
  logic [1:0]  ma, mb, mf, mi, mj;
  logic [2:0]  mc;
  logic        md, me, mg, mh;
  logic [4:0]  op;
  logic        rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_en, mem_rw, fault;
  logic [3:0]  state;

  control_sequencer #(.MFC_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ir(ir), .cond_true(cond_true), .mfc(mfc),
    .ma(ma), .mb(mb), .mf(mf), .mi(mi), .mj(mj), .mc(mc),
    .md(md), .me(me), .mg(mg), .mh(mh), .op(op),
    .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .flags_ld(flags_ld),
    .mem_en(mem_en), .mem_rw(mem_rw), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ma, mb;
    logic [2:0] mc;
    logic       md, me;
    logic [1:0] mf;
    logic       mg, mh;
    logic [1:0] mi, mj;
    logic [4:0] op;
    logic       rf_ld, ir_ld, mar_ld, mdr_ld, flags_ld, mem_en, mem_rw, fault;
  } outs_t;

  typedef struct packed {
    logic       mfc;
    logic       cond;
    logic [3:0] st;
    outs_t      o;
  } rec_t;

  rec_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   faulted;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o = '{ma:ma, mb:mb, mc:mc, md:md, me:me, mf:mf, mg:mg, mh:mh, mi:mi, mj:mj, op:op,
           rf_ld:rf_ld, ir_ld:ir_ld, mar_ld:mar_ld, mdr_ld:mdr_ld, flags_ld:flags_ld,
           mem_en:mem_en, mem_rw:mem_rw, fault:fault};
    return o;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [3:0] st, input outs_t o, input logic m, input logic c);
    rec_t r;
    r.mfc = m; r.cond = c; r.st = st; r.o = o;
    q.push_back(r);
  endtask

  task automatic push_fault();
    outs_t o;
    o = '0;
    o.fault = 1'b1;
    for (int i = 0; i < 4; i++) push(4'd15, o, rb(), rb());
    faulted = 1'b1;
  endtask

  // Memory wait of d cycles: mfc arrives on cycle d, or the timeout fires after LIMIT idle cycles.
  task automatic wait_phase(input logic [3:0] st, input int d, input bit is_store, output bit ok);
    outs_t o;
    for (int i = 1; i <= LIMIT; i++) begin
      o = '0;
      o.mem_en = 1'b1;
      o.mem_rw = !is_store;
      o.mh     = !is_store;
      if (i == d) begin
        o.ir_ld  = (st == 4'd3);
        o.mdr_ld = (st == 4'd7);
        push(st, o, 1'b1, rb());
        ok = 1'b1;
        return;
      end
      push(st, o, 1'b0, rb());
    end
    ok = 1'b0;
    push_fault();
  endtask

  task automatic build(input logic [31:0] iv, input logic c, input int fd, input int mem_d);
    outs_t o;
    bit    ok;
    q.delete();
    faulted = 1'b0;
    ir = iv;
    o = '0; o.ma = 2; o.md = 1; o.op = 5'h10; o.mar_ld = 1;
    push(4'd1, o, rb(), rb());
    o = '0; o.ma = 2; o.mb = 3; o.md = 1; o.op = 5'h04; o.mc = 3; o.rf_ld = 1; o.mem_en = 1; o.mem_rw = 1;
    push(4'd2, o, rb(), rb());
    wait_phase(4'd3, fd, 1'b0, ok);
    if (!ok) return;
    o = '0;
    push(4'd4, o, rb(), c);
    if (!c) return;
    if (iv[27:26] == 2'b00) begin
      o = '0; o.mb = 1;
      o.rf_ld    = !(iv[24:21] >= 4'd8 && iv[24:21] <= 4'd11);
      o.flags_ld = iv[20];
      push(4'd5, o, rb(), rb());
    end else if (iv[27:26] == 2'b01) begin
      o = '0; o.mb = 2; o.md = 1; o.op = iv[23] ? 5'h04 : 5'h02; o.mar_ld = 1;
      if (!iv[20]) begin o.mdr_ld = 1; o.mj = 2; o.mg = 1; end
      push(4'd6, o, rb(), rb());
      if (iv[20]) begin
        wait_phase(4'd7, mem_d, 1'b0, ok);
        if (ok) begin
          o = '0; o.mf = 1; o.rf_ld = 1;
          push(4'd8, o, rb(), rb());
        end
      end else begin
        wait_phase(4'd9, mem_d, 1'b1, ok);
      end
    end else if (iv[27:25] == 3'b101) begin
      if (iv[24]) begin
        o = '0; o.ma = 2; o.md = 1; o.op = 5'h10; o.mc = 2; o.rf_ld = 1;
        push(4'd10, o, rb(), rb());
      end
      o = '0; o.ma = 2; o.mb = 2; o.md = 1; o.op = 5'h04; o.mc = 3; o.rf_ld = 1;
      push(4'd11, o, rb(), rb());
    end else begin
      push_fault();
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+1 of the next unplayed cycle.
  task automatic run_recs(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      mfc       = q[i].mfc;
      cond_true = q[i].cond;
      #2;
      chk($sformatf("ir=%h rec%0d st%0d", ir, i, q[i].st), {state, observed()}, {q[i].st, q[i].o});
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("async_reset", {state, observed()}, 64'd0);
    @(posedge clk);
    #1;
    chk("held_reset", {state, observed()}, 64'd0);
    reset = 1'b0;
    mfc   = rb();
    #1;
    chk("idle_after_release", {state, observed()}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_instr(input logic [31:0] iv, input logic c, input int fd, input int mem_d);
    build(iv, c, fd, mem_d);
    run_recs(q.size());
    if (faulted) do_reset();
  endtask

  function automatic int rand_delay();
    if ($urandom_range(0, 9) < 8) return $urandom_range(1, 4);
    return LIMIT - 1 + $urandom_range(0, 2);
  endfunction

  initial begin
    logic [31:0] r;
    int          kind;
    reset = 1'b1; mfc = 1'b0; cond_true = 1'b0; ir = 32'd0;
    #1;
    chk("reset_state", {state, observed()}, 64'd0);
    do_reset();

    do_instr(32'hE0812003, 1'b1, 1, 1);
    do_instr(32'hE5912004, 1'b1, 1, 3);
    do_instr(32'hEB000010, 1'b1, 2, 1);
    do_instr(32'h00812003, 1'b0, 1, 1);
    do_instr(32'hE5812004, 1'b1, 1, 2);
    do_instr(32'hE5912004, 1'b1, LIMIT, LIMIT);
    do_instr(32'hE0812003, 1'b1, LIMIT + 1, 1);
    do_instr(32'hEE000000, 1'b1, 1, 1);

    build(32'hE5912004, 1'b1, 1, 10);
    run_recs(6);
    mfc = 1'b0;
    #1;
    chk("ld_wait_before_reset", {60'd0, state}, 64'd7);
    do_reset();

    for (int n = 0; n < 200; n++) begin
      r    = $urandom;
      kind = $urandom_range(0, 9);
      if (kind <= 2) r[27:26] = 2'b00;
      else if (kind <= 4) begin r[27:26] = 2'b01; r[20] = 1'b1; end
      else if (kind <= 6) begin r[27:26] = 2'b01; r[20] = 1'b0; end
      else if (kind <= 8) r[27:25] = 3'b101;
      else if (rb()) r[27:26] = 2'b11;
      else r[27:25] = 3'b100;
      do_instr(r, 1'($urandom_range(0, 4) != 0), rand_delay(), rand_delay());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
